cv_keypad_decoder: RTL and testbench

- Console-side scanner and decoder for the two ColecoVision controller ports. It is the inverse of the joystick-to-port encoder.
- It drives the keypad select (p5) and joystick select (p8) lines, waits for the lines to settle, then samples p1..p4 and p6.
- Samples are debounced and decoded back into a keypad key index, joystick directions and two fire buttons.
- Key press and release events are pushed into a small FIFO for a test/OSD/host consumer.

---
 rtl/cv_ctrl_pkg.sv | 88 ++++++++
 rtl/cv_evt_fifo.sv | 83 ++++++++
 rtl/cv_keypad_decoder.sv | 233 +++++++++++++++++++++++
 tb/tb_cv_keypad_decoder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv_ctrl_pkg.sv
// Shared ColecoVision controller definitions: keypad line codes, event byte layout,
// scanner FSM states and the keypad decode helper.
package cv_ctrl_pkg;

    // Keypad codes as driven on {p1,p2,p3,p4} while p5 is low (lines are active-low).
    localparam logic [3:0] cv_key_0_c      = 4'b0011;
    localparam logic [3:0] cv_key_1_c      = 4'b1110;
    localparam logic [3:0] cv_key_2_c      = 4'b1101;
    localparam logic [3:0] cv_key_3_c      = 4'b0110;
    localparam logic [3:0] cv_key_4_c      = 4'b0001;
    localparam logic [3:0] cv_key_5_c      = 4'b1001;
    localparam logic [3:0] cv_key_6_c      = 4'b0111;
    localparam logic [3:0] cv_key_7_c      = 4'b1100;
    localparam logic [3:0] cv_key_8_c      = 4'b1000;
    localparam logic [3:0] cv_key_9_c      = 4'b1011;
    localparam logic [3:0] cv_key_star_c   = 4'b1010;
    localparam logic [3:0] cv_key_pound_c  = 4'b0101;
    localparam logic [3:0] cv_key_purple_c = 4'b0100;
    localparam logic [3:0] cv_key_blue_c   = 4'b0010;
    localparam logic [3:0] cv_key_none_c   = 4'b1111;

    localparam logic [3:0] KEY_NONE = 4'hF;

    // Event byte: {port, press/release, 2'b00, key[3:0]}.
    localparam int EVT_W         = 8;
    localparam int EVT_PORT_BIT  = 7;
    localparam int EVT_PRESS_BIT = 6;
    localparam int EVT_KEY_MSB   = 3;
    localparam int EVT_KEY_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_KP    = 3'd1,
        ST_SAMPLE_KP  = 3'd2,
        ST_WAIT_JOY   = 3'd3,
        ST_SAMPLE_JOY = 3'd4,
        ST_EMIT       = 3'd5
    } cv_scan_state_e;

    typedef struct packed {
        logic [3:0] idx;
        logic [3:0] dir;   // {up, down, left, right}
        logic [1:0] fire;  // {fire2, fire1}
    } cv_scan_t;

    typedef struct packed {
        logic       bad;
        logic [3:0] idx;
    } cv_key_dec_t;

    localparam cv_scan_t SCAN_IDLE = '{idx: KEY_NONE, dir: 4'b0000, fire: 2'b00};

    function automatic cv_key_dec_t cv_decode_key(input logic [3:0] code);
        cv_key_dec_t dec;
        dec = '{bad: 1'b0, idx: KEY_NONE};
        case (code)
            cv_key_0_c:      dec.idx = 4'd0;
            cv_key_1_c:      dec.idx = 4'd1;
            cv_key_2_c:      dec.idx = 4'd2;
            cv_key_3_c:      dec.idx = 4'd3;
            cv_key_4_c:      dec.idx = 4'd4;
            cv_key_5_c:      dec.idx = 4'd5;
            cv_key_6_c:      dec.idx = 4'd6;
            cv_key_7_c:      dec.idx = 4'd7;
            cv_key_8_c:      dec.idx = 4'd8;
            cv_key_9_c:      dec.idx = 4'd9;
            cv_key_star_c:   dec.idx = 4'd10;
            cv_key_pound_c:  dec.idx = 4'd11;
            cv_key_purple_c: dec.idx = 4'd12;
            cv_key_blue_c:   dec.idx = 4'd13;
            cv_key_none_c:   dec.idx = KEY_NONE;
            default:         dec.bad = 1'b1;
        endcase
        return dec;
    endfunction

    function automatic logic [EVT_W-1:0] cv_make_evt(input logic       port,
                                                     input logic       press,
                                                     input logic [3:0] key);
        logic [EVT_W-1:0] evt;
        evt                           = '0;
        evt[EVT_PORT_BIT]             = port;
        evt[EVT_PRESS_BIT]            = press;
        evt[EVT_KEY_MSB:EVT_KEY_LSB]  = key;
        return evt;
    endfunction

endpackage

// File: rtl/cv_evt_fifo.sv
// Synchronous event FIFO with a registered head word and a sticky drop flag.
module cv_evt_fifo
    import cv_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = EVT_W
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_wr_en;
    logic [AW-1:0]    w_rd_next;
    logic [AW:0]      w_count_next;

    assign w_full    = (r_count == CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && ready_i;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_wr_en   = push_i && (!w_full || w_pop);
    assign w_rd_next = w_pop ? r_rd_ptr + PTR_ONE : r_rd_ptr;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_count_next = r_count;
        if (w_wr_en && !w_pop)
            w_count_next = r_count + CNT_ONE;
        else if (!w_wr_en && w_pop)
            w_count_next = r_count - CNT_ONE;
    end

    // NOTE: storage has no reset; only entries below r_count are ever observed.
    always_ff @(posedge clk_i) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (push_i && !w_wr_en)
                r_overflow <= 1'b1;
            if (w_count_next != '0)
                r_head <= (w_wr_en && (w_rd_next == r_wr_ptr)) ? data_i : r_mem[w_rd_next];
        end
    end

    assign valid_o    = !w_empty;
    assign data_o     = r_head;
    assign overflow_o = r_overflow;

endmodule

// File: rtl/cv_keypad_decoder.sv
// ColecoVision two-port controller scanner: drives p5/p8, samples the data lines,
// debounces full scans and queues keypad press/release events.
module cv_keypad_decoder
    import cv_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 8,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            clk_en_i,
    input  logic            enable_i,
    input  logic [1:0]      ctrl_p1_i,
    input  logic [1:0]      ctrl_p2_i,
    input  logic [1:0]      ctrl_p3_i,
    input  logic [1:0]      ctrl_p4_i,
    input  logic [1:0]      ctrl_p6_i,
    output logic [1:0]      ctrl_p5_o,
    output logic [1:0]      ctrl_p8_o,
    output logic [1:0][3:0] key_idx_o,
    output logic [1:0][3:0] dir_o,
    output logic [1:0][1:0] fire_o,
    output logic [1:0]      bad_code_o,
    output logic            evt_valid_o,
    output logic [7:0]      evt_data_o,
    input  logic            evt_ready_i,
    output logic            overflow_o
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [3:0] DB_MAX      = 4'(DEBOUNCE);

    cv_scan_state_e    r_state;
    cv_scan_state_e    w_state_next;
    logic [7:0]        r_settle_cnt;
    logic              w_settle_done;
    logic [1:0]        r_p5;
    logic [1:0]        r_p8;

    logic [9:0]        r_pin_meta;
    logic [9:0]        r_pin_sync;
    logic [1:0]        w_p1, w_p2, w_p3, w_p4, w_p6;

    cv_key_dec_t [1:0] w_kp_dec;
    logic [1:0][3:0]   r_kp_idx;
    logic [1:0]        r_kp_fire2;
    logic [1:0]        r_bad;

    cv_scan_t [1:0]    w_raw;
    cv_scan_t [1:0]    r_prev;
    cv_scan_t [1:0]    r_commit;
    logic [1:0][3:0]   r_db_cnt;
    logic [1:0][3:0]   w_cnt_next;
    logic [1:0]        w_commit;

    logic [3:0]        w_evt_mask_new;
    logic [3:0][7:0]   w_evt_data_new;
    logic [3:0]        r_evt_mask;
    logic [3:0][7:0]   r_evt_data;
    logic [3:0]        w_emit_sel;
    logic [7:0]        w_emit_data;
    logic [3:0]        w_mask_next;
    logic              w_push;
    logic              w_kp_sel;
    logic              w_joy_sel;

    // Controller lines are asynchronous to clk_i; settle time hides the sync latency.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_pin_meta <= '1;
            r_pin_sync <= '1;
        end else begin
            r_pin_meta <= {ctrl_p6_i, ctrl_p4_i, ctrl_p3_i, ctrl_p2_i, ctrl_p1_i};
            r_pin_sync <= r_pin_meta;
        end
    end

    assign w_p1 = r_pin_sync[1:0];
    assign w_p2 = r_pin_sync[3:2];
    assign w_p3 = r_pin_sync[5:4];
    assign w_p4 = r_pin_sync[7:6];
    assign w_p6 = r_pin_sync[9:8];

    assign w_settle_done = (r_settle_cnt == SETTLE_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:       if (clk_en_i && enable_i)      w_state_next = ST_WAIT_KP;
            ST_WAIT_KP:    if (clk_en_i && w_settle_done) w_state_next = ST_SAMPLE_KP;
            ST_SAMPLE_KP:  if (clk_en_i)                  w_state_next = ST_WAIT_JOY;
            ST_WAIT_JOY:   if (clk_en_i && w_settle_done) w_state_next = ST_SAMPLE_JOY;
            ST_SAMPLE_JOY: if (clk_en_i)                  w_state_next = ST_EMIT;
            ST_EMIT:       if (w_mask_next == '0)         w_state_next = ST_IDLE;
            default:                                      w_state_next = ST_IDLE;
        endcase
    end

    // Selects follow the next state, so they move only on state entry and never overlap.
    assign w_kp_sel  = (w_state_next == ST_WAIT_KP)  || (w_state_next == ST_SAMPLE_KP);
    assign w_joy_sel = (w_state_next == ST_WAIT_JOY) || (w_state_next == ST_SAMPLE_JOY);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_p5         <= 2'b11;
            r_p8         <= 2'b11;
        end else begin
            r_state <= w_state_next;
            r_p5    <= w_kp_sel  ? 2'b00 : 2'b11;
            r_p8    <= w_joy_sel ? 2'b00 : 2'b11;
            if (clk_en_i && ((r_state == ST_WAIT_KP) || (r_state == ST_WAIT_JOY)))
                r_settle_cnt <= w_settle_done ? 8'd0 : r_settle_cnt + 8'd1;
        end
    end

    always_comb begin
        w_kp_dec = '0;
        for (int n = 0; n < 2; n++)
            w_kp_dec[n] = cv_decode_key({w_p1[n], w_p2[n], w_p3[n], w_p4[n]});
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_kp_idx   <= {KEY_NONE, KEY_NONE};
            r_kp_fire2 <= '0;
            r_bad      <= '0;
        end else if ((r_state == ST_SAMPLE_KP) && clk_en_i) begin
            r_kp_idx   <= {w_kp_dec[1].idx, w_kp_dec[0].idx};
            r_kp_fire2 <= ~w_p6;
            r_bad      <= r_bad | {w_kp_dec[1].bad, w_kp_dec[0].bad};
        end
    end

    // Raw scan per port, debounce counter and the press/release events a commit produces.
    always_comb begin
        w_raw          = '0;
        w_cnt_next     = '0;
        w_commit       = '0;
        w_evt_mask_new = '0;
        w_evt_data_new = '0;
        for (int n = 0; n < 2; n++) begin
            w_raw[n].idx  = r_kp_idx[n];
            w_raw[n].dir  = ~{w_p1[n], w_p2[n], w_p3[n], w_p4[n]};
            w_raw[n].fire = {r_kp_fire2[n], ~w_p6[n]};
            if (w_raw[n] != r_prev[n])
                w_cnt_next[n] = 4'd1;
            else if (r_db_cnt[n] >= DB_MAX)
                w_cnt_next[n] = DB_MAX;
            else
                w_cnt_next[n] = r_db_cnt[n] + 4'd1;
            w_commit[n] = (w_cnt_next[n] == DB_MAX) && (w_raw[n] != r_commit[n]);
            if (w_commit[n] && (w_raw[n].idx != r_commit[n].idx)) begin
                if (r_commit[n].idx != KEY_NONE) begin
                    w_evt_mask_new[2*n] = 1'b1;
                    w_evt_data_new[2*n] = cv_make_evt(1'(n), 1'b0, r_commit[n].idx);
                end
                if (w_raw[n].idx != KEY_NONE) begin
                    w_evt_mask_new[2*n+1] = 1'b1;
                    w_evt_data_new[2*n+1] = cv_make_evt(1'(n), 1'b1, w_raw[n].idx);
                end
            end
        end
    end

    // Lowest pending slot goes first: port 0 release, port 0 press, port 1 release, port 1 press.
    always_comb begin
        w_emit_sel  = '0;
        w_emit_data = '0;
        for (int i = 3; i >= 0; i--) begin
            if (r_evt_mask[i]) begin
                w_emit_sel    = '0;
                w_emit_sel[i] = 1'b1;
                w_emit_data   = r_evt_data[i];
            end
        end
    end

    assign w_mask_next = r_evt_mask & ~w_emit_sel;
    assign w_push      = (r_state == ST_EMIT) && (r_evt_mask != '0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_prev     <= {SCAN_IDLE, SCAN_IDLE};
            r_commit   <= {SCAN_IDLE, SCAN_IDLE};
            r_db_cnt   <= '0;
            r_evt_mask <= '0;
            r_evt_data <= '0;
        end else if ((r_state == ST_SAMPLE_JOY) && clk_en_i) begin
            r_prev     <= w_raw;
            r_db_cnt   <= w_cnt_next;
            r_evt_mask <= w_evt_mask_new;
            r_evt_data <= w_evt_data_new;
            for (int n = 0; n < 2; n++)
                if (w_commit[n])
                    r_commit[n] <= w_raw[n];
        end else if (r_state == ST_EMIT) begin
            r_evt_mask <= w_mask_next;
        end
    end

    cv_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_evt_fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .push_i     (w_push),
        .data_i     (w_emit_data),
        .ready_i    (evt_ready_i),
        .valid_o    (evt_valid_o),
        .data_o     (evt_data_o),
        .overflow_o (overflow_o)
    );

    always_comb begin
        key_idx_o = '0;
        dir_o     = '0;
        fire_o    = '0;
        for (int n = 0; n < 2; n++) begin
            key_idx_o[n] = r_commit[n].idx;
            dir_o[n]     = r_commit[n].dir;
            fire_o[n]    = r_commit[n].fire;
        end
    end

    assign ctrl_p5_o  = r_p5;
    assign ctrl_p8_o  = r_p8;
    assign bad_code_o = r_bad;

endmodule

// File: tb/tb_cv_keypad_decoder.sv
// Directed bench for cv_keypad_decoder: a behavioural controller responder answers
// the select lines while scans are triggered one at a time.
module tb_cv_keypad_decoder;

    logic            clk_i;
    logic            reset_n_i;
    logic            clk_en_i;
    logic            enable_i;
    logic [1:0]      ctrl_p1_i, ctrl_p2_i, ctrl_p3_i, ctrl_p4_i, ctrl_p6_i;
    logic [1:0]      ctrl_p5_o, ctrl_p8_o;
    logic [1:0][3:0] key_idx_o;
    logic [1:0][3:0] dir_o;
    logic [1:0][1:0] fire_o;
    logic [1:0]      bad_code_o;
    logic            evt_valid_o;
    logic [7:0]      evt_data_o;
    logic            evt_ready_i;
    logic            overflow_o;

    logic [3:0] kp_code [2];
    logic [3:0] joy_dir [2];
    logic [1:0] fire1;
    logic [1:0] fire2;

    int n_checks    = 0;
    int n_pass      = 0;
    int overlap_cnt = 0;

    cv_keypad_decoder #(
        .SETTLE_CYC (8),
        .DEBOUNCE   (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .clk_en_i    (clk_en_i),
        .enable_i    (enable_i),
        .ctrl_p1_i   (ctrl_p1_i),
        .ctrl_p2_i   (ctrl_p2_i),
        .ctrl_p3_i   (ctrl_p3_i),
        .ctrl_p4_i   (ctrl_p4_i),
        .ctrl_p6_i   (ctrl_p6_i),
        .ctrl_p5_o   (ctrl_p5_o),
        .ctrl_p8_o   (ctrl_p8_o),
        .key_idx_o   (key_idx_o),
        .dir_o       (dir_o),
        .fire_o      (fire_o),
        .bad_code_o  (bad_code_o),
        .evt_valid_o (evt_valid_o),
        .evt_data_o  (evt_data_o),
        .evt_ready_i (evt_ready_i),
        .overflow_o  (overflow_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        clk_en_i = 1'b0;
        forever begin
            @(negedge clk_i);
            clk_en_i = ~clk_en_i;
        end
    end

    // Controller model: keypad code while p5 is low, inverted joystick while p8 is low.
    always_comb begin
        ctrl_p1_i = 2'b11;
        ctrl_p2_i = 2'b11;
        ctrl_p3_i = 2'b11;
        ctrl_p4_i = 2'b11;
        ctrl_p6_i = 2'b11;
        for (int n = 0; n < 2; n++) begin
            if (!ctrl_p5_o[n]) begin
                {ctrl_p1_i[n], ctrl_p2_i[n], ctrl_p3_i[n], ctrl_p4_i[n]} = kp_code[n];
                ctrl_p6_i[n] = ~fire2[n];
            end else if (!ctrl_p8_o[n]) begin
                {ctrl_p1_i[n], ctrl_p2_i[n], ctrl_p3_i[n], ctrl_p4_i[n]} = ~joy_dir[n];
                ctrl_p6_i[n] = ~fire1[n];
            end
        end
    end

    always @(negedge clk_i) begin
        if (reset_n_i && ((~ctrl_p5_o & ~ctrl_p8_o) != 2'b00))
            overlap_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One full pass: enable is dropped once the keypad phase starts, so the FSM parks in IDLE.
    task automatic scan();
        int t;
        enable_i = 1'b1;
        t = 0;
        while ((ctrl_p5_o != 2'b00) && (t < 400)) begin
            @(negedge clk_i);
            t++;
        end
        check("scan_kp_select", {ctrl_p8_o, ctrl_p5_o}, 4'b1100);
        enable_i = 1'b0;
        t = 0;
        while ((ctrl_p8_o != 2'b00) && (t < 400)) begin
            @(negedge clk_i);
            t++;
        end
        check("scan_joy_select", {ctrl_p8_o, ctrl_p5_o}, 4'b0011);
        t = 0;
        while ((ctrl_p8_o != 2'b11) && (t < 400)) begin
            @(negedge clk_i);
            t++;
        end
        check("scan_end_select", ctrl_p8_o, 2'b11);
        repeat (12) @(negedge clk_i);
    endtask

    task automatic scans(input int k);
        for (int i = 0; i < k; i++)
            scan();
    endtask

    task automatic pop_evt();
        evt_ready_i = 1'b1;
        @(negedge clk_i);
        evt_ready_i = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_p5"},       ctrl_p5_o,   2'b11);
        check({tag, "_p8"},       ctrl_p8_o,   2'b11);
        check({tag, "_key_idx"},  key_idx_o,   8'hFF);
        check({tag, "_dir"},      dir_o,       8'h00);
        check({tag, "_fire"},     fire_o,      4'h0);
        check({tag, "_bad"},      bad_code_o,  2'b00);
        check({tag, "_valid"},    evt_valid_o, 1'b0);
        check({tag, "_data"},     evt_data_o,  8'h00);
        check({tag, "_overflow"}, overflow_o,  1'b0);
    endtask

    initial begin
        int t;
        reset_n_i   = 1'b0;
        enable_i    = 1'b0;
        evt_ready_i = 1'b0;
        kp_code[0]  = 4'b1111;
        kp_code[1]  = 4'b1111;
        joy_dir[0]  = 4'b0000;
        joy_dir[1]  = 4'b0000;
        fire1       = 2'b00;
        fire2       = 2'b00;
        repeat (4) @(negedge clk_i);
        check_reset_state("reset");
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // Key 1 on port 0: committed only after the third identical scan.
        kp_code[0] = 4'b1110;
        scans(2);
        check("key1_p0_after2", key_idx_o[0], 4'hF);
        check("key1_p0_nevt", evt_valid_o, 1'b0);
        scan();
        check("key1_p0_idx", key_idx_o[0], 4'd1);
        check("key1_p0_valid", evt_valid_o, 1'b1);
        check("key1_p0_evt", evt_data_o, 8'h41);
        pop_evt();
        check("key1_p0_popped", evt_valid_o, 1'b0);

        // Port 1: press 1, then move to key 11 (#).
        kp_code[1] = 4'b1110;
        scans(3);
        check("key1_p1_idx", key_idx_o[1], 4'd1);
        check("key1_p1_evt", evt_data_o, 8'hC1);
        pop_evt();
        kp_code[1] = 4'b0101;
        scans(2);
        check("key11_p1_after2", key_idx_o[1], 4'd1);
        scan();
        check("key11_p1_idx", key_idx_o, {4'd11, 4'd1});
        check("key11_rel_evt", evt_data_o, 8'h81);
        pop_evt();
        check("key11_press_valid", evt_valid_o, 1'b1);
        check("key11_press_evt", evt_data_o, 8'hCB);
        pop_evt();
        check("key11_empty", evt_valid_o, 1'b0);

        // Joystick up+right with fire1 on port 0: outputs change, no keypad event.
        joy_dir[0] = 4'b1001;
        fire1[0]   = 1'b1;
        scans(2);
        check("joy_after2", dir_o[0], 4'b0000);
        scan();
        check("joy_dir", dir_o, {4'b0000, 4'b1001});
        check("joy_fire", fire_o, {2'b00, 2'b01});
        check("joy_keys_held", key_idx_o, {4'd11, 4'd1});
        check("joy_no_evt", evt_valid_o, 1'b0);

        // Release everything: port 0 release then port 1 release.
        joy_dir[0] = 4'b0000;
        fire1[0]   = 1'b0;
        kp_code[0] = 4'b1111;
        kp_code[1] = 4'b1111;
        scans(3);
        check("rel_keys", key_idx_o, 8'hFF);
        check("rel_dir", dir_o[0], 4'b0000);
        check("rel_evt0", evt_data_o, 8'h01);
        pop_evt();
        check("rel_evt1", evt_data_o, 8'h8B);
        pop_evt();
        check("rel_empty", evt_valid_o, 1'b0);

        // Bouncing code: never stable long enough to commit.
        for (int i = 0; i < 6; i++) begin
            kp_code[0] = (i % 2 == 0) ? 4'b1110 : 4'b1101;
            scan();
        end
        check("bounce_key", key_idx_o[0], 4'hF);
        check("bounce_empty", evt_valid_o, 1'b0);

        // Overflow: 2 events, then 3 more into a depth-4 FIFO with no consumer.
        kp_code[0] = 4'b1110;
        kp_code[1] = 4'b1101;
        scans(3);
        check("ovf_stepA_keys", key_idx_o, {4'd2, 4'd1});
        check("ovf_stepA_flag", overflow_o, 1'b0);
        kp_code[0] = 4'b0110;
        kp_code[1] = 4'b1111;
        scans(3);
        check("ovf_stepB_keys", key_idx_o, {4'hF, 4'd3});
        check("ovf_flag", overflow_o, 1'b1);
        check("ovf_evt0", evt_data_o, 8'h41);
        pop_evt();
        check("ovf_evt1", evt_data_o, 8'hC2);
        pop_evt();
        check("ovf_evt2", evt_data_o, 8'h01);
        pop_evt();
        check("ovf_evt3", evt_data_o, 8'h43);
        pop_evt();
        check("ovf_empty", evt_valid_o, 1'b0);

        // Undefined code 0000 on port 0: flagged at once, decodes as no key.
        kp_code[0] = 4'b0000;
        scan();
        check("bad_flag_first", bad_code_o, 2'b01);
        scans(2);
        check("bad_key", key_idx_o[0], 4'hF);
        check("bad_rel_evt", evt_data_o, 8'h03);
        check("bad_ovf_sticky", overflow_o, 1'b1);
        pop_evt();

        // Reset in the middle of the joystick phase.
        kp_code[0] = 4'b1110;
        enable_i   = 1'b1;
        t = 0;
        while ((ctrl_p8_o != 2'b00) && (t < 400)) begin
            @(negedge clk_i);
            t++;
        end
        check("mid_reset_in_joy", ctrl_p8_o, 2'b00);
        enable_i  = 1'b0;
        reset_n_i = 1'b0;
        #1;
        check_reset_state("mid_reset");
        @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        scans(3);
        check("recover_key", key_idx_o[0], 4'd1);
        check("recover_evt", evt_data_o, 8'h41);
        check("select_overlap", overlap_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
